// File: rtl/iram_loader.sv
// Boot-time IRAM writer: parses SYNC/len/data/checksum frames from the UART receiver,
// writes the data bytes from address 0 and holds the CPU in reset until a frame loads cleanly.
module iram_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 50000,
  parameter int         TO_W      = 16
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       start,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       mem_wren,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      sum_q, sum_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      mem_addr_q, mem_addr_d;
  logic [7:0]      mem_data_q, mem_data_d;
  logic            mem_wren_q, mem_wren_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            load_done_q, load_done_d;
  logic            load_err_q, load_err_d;

  logic            is_sync;
  logic            in_frame;

  assign is_sync  = rx_valid && (rx_data == SYNC_BYTE);
  assign in_frame = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    to_d        = to_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_wren_d  = 1'b0;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;

    case (state_q)
      IDLE: begin
        if (is_sync) begin
          state_d = LEN;
          to_d    = '0;
        end
      end
      LEN: begin
        if (rx_valid) begin
          cnt_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          addr_d  = 8'd0;
          sum_d   = 8'd0;
          to_d    = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (rx_valid) begin
          mem_addr_d = addr_q;
          mem_data_d = rx_data;
          mem_wren_d = 1'b1;
          addr_d     = addr_q + 8'd1;
          sum_d      = sum_q + rx_data;
          cnt_d      = cnt_q - 9'd1;
          to_d       = '0;
          if (cnt_q == 9'd1) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        // A sync-valued byte here is just a checksum value, not a restart.
        if (rx_valid) begin
          to_d = '0;
          if (rx_data == sum_q) begin
            state_d     = DONE;
            cpu_hold_d  = 1'b0;
            load_done_d = 1'b1;
          end else begin
            state_d    = ERR;
            load_err_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d     = IDLE;
          load_done_d = 1'b0;
          cpu_hold_d  = 1'b1;
        end
      end
      ERR: begin
        if (is_sync) begin
          state_d    = LEN;
          load_err_d = 1'b0;
          to_d       = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Idle-gap watchdog; a byte arriving on the expiry cycle wins.
    if (in_frame && !rx_valid) begin
      if (to_q == TO_LAST) begin
        state_d     = ERR;
        load_err_d  = 1'b1;
        load_done_d = 1'b0;
        cpu_hold_d  = 1'b1;
        to_d        = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      sum_q       <= '0;
      to_q        <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_wren_q  <= 1'b0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      to_q        <= to_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_wren_q  <= mem_wren_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_wren  = mem_wren_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_iram_loader.sv
// Self-checking bench for iram_loader: directed frames from the test plan plus
// randomized frames compared against an expected write list built from the frame itself.
module tb_iram_loader;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TMO  = 20;

  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_wren;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  int total = 0;
  int bad = 0;
  logic       model_done = 1'b0;
  logic [15:0] wr_q[$];
  logic [7:0]  tx_data[$];

  iram_loader #(
    .SYNC_BYTE(SYNC),
    .TIMEOUT  (TMO),
    .TO_W     (16)
  ) dut (
    .CLK      (CLK),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .start    (start),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wren (mem_wren),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 CLK = ~CLK;

  // IRAM-side view: every write the DUT presents, sampled mid-cycle.
  always @(negedge CLK) begin
    if (rst && mem_wren) wr_q.push_back({mem_addr, mem_data});
  end

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_wr, input logic [7:0] idx, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check_output("wren_lat", 32'(mem_wren), 32'(exp_wr));
    if (exp_wr) begin
      check_output("wr_addr", 32'(mem_addr), 32'(idx));
      check_output("wr_data", 32'(mem_data), 32'(b));
    end
    repeat (gap) tick();
    if (gap > 0) check_output("wren_pulse", 32'(mem_wren), 32'd0);
  endtask

  function automatic int pick_gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
  endfunction

  task automatic prepare(input int n);
    tx_data.delete();
    for (int i = 0; i < n; i++) tx_data.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("start_hold", 32'(cpu_hold), 32'd1);
    check_output("start_done", 32'(load_done), 32'd0);
    model_done = 1'b0;
  endtask

  // One full frame from tx_data; csum_delta != 0 corrupts the checksum.
  task automatic apply_stimulus(input logic [7:0] len_byte, input logic [7:0] csum_delta, input int max_gap);
    int n;
    int m;
    logic [7:0] sum;
    logic good;
    n = tx_data.size();
    sum = 8'h00;
    good = (csum_delta == 8'h00);
    wr_q.delete();
    send_byte(SYNC, 1'b0, 8'h00, pick_gap(max_gap));
    send_byte(len_byte, 1'b0, 8'h00, pick_gap(max_gap));
    for (int i = 0; i < n; i++) begin
      sum = sum + tx_data[i];
      send_byte(tx_data[i], 1'b1, 8'(i), pick_gap(max_gap));
    end
    check_output("pre_csum_done", 32'(load_done), 32'd0);
    check_output("pre_csum_hold", 32'(cpu_hold), 32'd1);
    send_byte(sum + csum_delta, 1'b0, 8'h00, 0);
    check_output("csum_done", 32'(load_done), 32'(good));
    check_output("csum_err", 32'(load_err), 32'(!good));
    check_output("csum_hold", 32'(cpu_hold), 32'(!good));
    tick();
    tick();
    check_output("wr_count", 32'(wr_q.size()), 32'(n));
    m = (wr_q.size() < n) ? wr_q.size() : n;
    for (int i = 0; i < m; i++) check_output("wr_entry", 32'(wr_q[i]), 32'({8'(i), tx_data[i]}));
    model_done = good;
  endtask

  initial begin
    // Reset values.
    repeat (2) @(posedge CLK);
    #1;
    check_output("rst_addr", 32'(mem_addr), 32'd0);
    check_output("rst_data", 32'(mem_data), 32'd0);
    check_output("rst_wren", 32'(mem_wren), 32'd0);
    check_output("rst_hold", 32'(cpu_hold), 32'd1);
    check_output("rst_done", 32'(load_done), 32'd0);
    check_output("rst_err", 32'(load_err), 32'd0);
    rst = 1'b1;
    tick();

    // Good 3-byte frame (checksum 66).
    tx_data = '{8'h11, 8'h22, 8'h33};
    apply_stimulus(8'h03, 8'h00, 2);

    // DONE ignores incoming bytes.
    wr_q.delete();
    send_byte(SYNC, 1'b0, 8'h00, 1);
    send_byte(8'h01, 1'b0, 8'h00, 1);
    send_byte(8'h44, 1'b0, 8'h00, 1);
    check_output("done_ignore_wr", 32'(wr_q.size()), 32'd0);
    check_output("done_ignore_flag", 32'(load_done), 32'd1);
    pulse_start();

    // Bad checksum, start is ignored in ERR, then recovery.
    tx_data = '{8'h10, 8'h20};
    apply_stimulus(8'h02, 8'h01, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_output("err_start_err", 32'(load_err), 32'd1);
    check_output("err_start_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h00, 1'b0, 8'h00, 1);
    check_output("err_noise", 32'(load_err), 32'd1);
    tx_data = '{8'h7F};
    apply_stimulus(8'h01, 8'h00, 0);
    pulse_start();

    // Noise in IDLE.
    wr_q.delete();
    send_byte(8'h00, 1'b0, 8'h00, 1);
    send_byte(8'hFF, 1'b0, 8'h00, 1);
    check_output("idle_noise_wr", 32'(wr_q.size()), 32'd0);
    check_output("idle_noise_hold", 32'(cpu_hold), 32'd1);

    // Full 256-byte frame, back to back.
    tx_data.delete();
    for (int i = 0; i < 256; i++) tx_data.push_back(8'(i));
    apply_stimulus(8'h00, 8'h00, 0);

    // start and rx_valid together in DONE: start wins, byte dropped.
    start = 1'b1;
    rx_valid = 1'b1;
    rx_data = SYNC;
    tick();
    start = 1'b0;
    rx_valid = 1'b0;
    check_output("both_hold", 32'(cpu_hold), 32'd1);
    check_output("both_done", 32'(load_done), 32'd0);
    check_output("both_wren", 32'(mem_wren), 32'd0);
    model_done = 1'b0;
    prepare(3);
    apply_stimulus(8'h03, 8'h00, 2);
    pulse_start();

    // Timeout after one data byte.
    wr_q.delete();
    send_byte(SYNC, 1'b0, 8'h00, 0);
    send_byte(8'h04, 1'b0, 8'h00, 0);
    send_byte(8'h01, 1'b1, 8'h00, 0);
    repeat (TMO - 1) tick();
    check_output("to_early_err", 32'(load_err), 32'd0);
    tick();
    check_output("to_err", 32'(load_err), 32'd1);
    check_output("to_hold", 32'(cpu_hold), 32'd1);
    check_output("to_done", 32'(load_done), 32'd0);
    check_output("to_wr_count", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) check_output("to_wr_entry", 32'(wr_q[0]), 32'h0001);
    prepare(5);
    apply_stimulus(8'h05, 8'h00, 3);
    pulse_start();

    // Asynchronous reset in the middle of DATA.
    prepare(5);
    send_byte(SYNC, 1'b0, 8'h00, 0);
    send_byte(8'h05, 1'b0, 8'h00, 0);
    send_byte(tx_data[0], 1'b1, 8'h00, 0);
    send_byte(tx_data[1], 1'b1, 8'h01, 0);
    #2 rst = 1'b0;
    #1;
    check_output("arst_wren", 32'(mem_wren), 32'd0);
    check_output("arst_addr", 32'(mem_addr), 32'd0);
    check_output("arst_data", 32'(mem_data), 32'd0);
    check_output("arst_hold", 32'(cpu_hold), 32'd1);
    check_output("arst_done", 32'(load_done), 32'd0);
    check_output("arst_err", 32'(load_err), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    model_done = 1'b0;
    prepare(5);
    apply_stimulus(8'h05, 8'h00, 2);

    // Randomized frames, some with corrupted checksums.
    for (int k = 0; k < 8; k++) begin
      int n;
      logic [7:0] delta;
      n = int'($urandom_range(1, 40));
      delta = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      if (model_done) pulse_start();
      prepare(n);
      apply_stimulus(8'(n), delta, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iram_loader.md
# iram_loader

Boot-time writer for the 256×8 instruction RAM. It takes a framed byte stream from the serial receiver and writes it into IRAM starting at address 0. It checks an 8-bit checksum and holds the processor in reset until a frame loads cleanly. It sits beside the processor core and drives the IRAM write port that the core itself never uses. While `cpu_hold` is high, the top level muxes IRAM address, data and wren from this block.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT`, default 50000: maximum idle cycles between bytes inside a frame.
- `TO_W`, default 16: timeout counter width. TIMEOUT must be less than 2^TO_W.
- `CLK` input, 1 bit: system clock. All state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `rx_data` input, 8 bits: received byte. Valid only while `rx_valid` is high.
- `rx_valid` input, 1 bit: single-cycle strobe, one per byte.
- `start` input, 1 bit: single-cycle pulse that re-enters load mode from DONE.
- `mem_addr` output, 8 bits: IRAM write address.
- `mem_data` output, 8 bits: IRAM write data.
- `mem_wren` output, 1 bit: IRAM write enable. One-cycle pulse.
- `cpu_hold` output, 1 bit: high keeps the processor in reset and gives IRAM ownership to the loader.
- `load_done` output, 1 bit: last frame loaded with a good checksum.
- `load_err` output, 1 bit: last frame failed on checksum or timeout.

## Operation
- Frame format: `SYNC_BYTE`, then length L, then L data bytes, then checksum C.
  - L = 0 means 256 data bytes.
  - C = (sum of the data bytes) mod 256.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE:
  - A byte equal to `SYNC_BYTE` moves to LEN.
  - Any other byte is discarded.
- LEN:
  - Latch the remaining count: L, with 0 mapped to 256 (9-bit counter).
  - Clear the address counter and the running sum.
  - Move to DATA.
- DATA, on each byte:
  - Register `mem_addr` = address counter and `mem_data` = `rx_data`.
  - Pulse `mem_wren`.
  - Increment the address, add the byte to the sum, decrement the count.
  - When the count reaches 0, move to CSUM.
  - Address never wraps within a frame; at most 256 writes.
- CSUM, on the byte:
  - If it equals the sum, go to DONE.
  - Otherwise go to ERR.
  - A sync-valued byte here is treated as a checksum, not as a new frame.
- DONE:
  - `cpu_hold` = 0, `load_done` = 1.
  - `rx_valid` is ignored.
  - A `start` pulse goes to IDLE, clears `load_done` and sets `cpu_hold` = 1.
  - If `start` and `rx_valid` arrive in the same cycle, `start` wins and the byte is discarded.
- ERR:
  - `load_err` = 1, `cpu_hold` = 1.
  - A `SYNC_BYTE` clears `load_err` and goes to LEN.
  - Other bytes are discarded.
  - `start` has no effect.
- Timeout:
  - The counter runs only in LEN, DATA and CSUM.
  - It clears on every `rx_valid`, and on entry to those states.
  - Reaching `TIMEOUT` moves to ERR.
  - If `rx_valid` arrives in the same cycle as the timeout, the byte wins and the counter clears.
- Partially written IRAM contents are never erased. Only `cpu_hold` protects the core from them.

## Timing
- Reset (`rst` = 0, asynchronous) sets:
  - state = IDLE;
  - `mem_addr` = 0, `mem_data` = 0, `mem_wren` = 0;
  - `cpu_hold` = 1, `load_done` = 0, `load_err` = 0;
  - all counters and the sum to 0.
- Reset mid-frame abandons the frame and returns to these values. No partial `mem_wren` is issued.
- Write latency: a data byte strobed at edge n gives `mem_wren` = 1, with its address and data, during cycle n+1 only. IRAM samples it at edge n+2.
- Back-to-back `rx_valid` on consecutive cycles is supported: one write per cycle, sequential addresses.
- State-change latency:
  - `load_done`/`cpu_hold` change in the cycle after the checksum byte's strobe.
  - The last data write and the checksum decision never overlap in the same cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Good 3-byte frame. Send A5, 03, 11, 22, 33, 66.
  - Expect writes (00,11), (01,22), (02,33), one cycle each.
  - Then `load_done` = 1 and `cpu_hold` = 0.
- Bad checksum. Send A5, 02, 10, 20, 31.
  - Expect 2 writes, then `load_err` = 1 and `cpu_hold` = 1.
  - Then send A5, 01, 7F, 7F: `load_done` = 1.
- Full 256-byte frame. Send A5, 00, data bytes i = 0..255, checksum 80.
  - Expect 256 writes at addresses 00..FF, no wrap, `load_done` = 1.
- Timeout. With `TIMEOUT` = 20, send A5, 04, 01, then stall 20 cycles.
  - Expect ERR with `load_err` = 1, and only address 00 written.
- Noise and reload:
  - Bytes 00, FF in IDLE cause no writes.
  - In DONE, `start` together with `rx_valid` gives IDLE, `cpu_hold` = 1, and the byte is dropped.
- Asynchronous reset during DATA (after 2 of 5 bytes): all outputs take their reset values immediately. The next good frame loads correctly.
